// File: rtl/biu_pkg.sv
// biu_pkg: shared BIU constants, SDRAM configuration field layout and word type
package biu_pkg;
  localparam logic [31:0] BIU_REG_ADDR = 32'h3FFF_FFFF;
  localparam int TBURST_LSB = 0;
  localparam int TBURST_W = 3;
  localparam int ADDR_MODE_LSB = 3;
  localparam int ADDR_MODE_W = 1;
  localparam int TLAT_LSB = 4;
  localparam int TLAT_W = 4;
  localparam int TPRE_LSB = 8;
  localparam int TPRE_W = 8;
  localparam int TWAIT_LSB = 16;
  localparam int TWAIT_W = 8;
  localparam int TCAS_LSB = 24;
  localparam int TCAS_W = 8;
  typedef struct packed {
    logic [TCAS_W-1:0] tcas;
    logic [TWAIT_W-1:0] twait;
    logic [TPRE_W-1:0] tpre;
    logic [TLAT_W-1:0] tlat;
    logic addr_mode;
    logic [TBURST_W-1:0] tburst;
  } sdram_cfg_t;
endpackage

// File: rtl/biu_regfile_if.sv
// biu_regfile_if: BIU write bus into the config register and SDRAM timing fields out
interface biu_regfile_if;
  import biu_pkg::*;
  logic MasterBusy;
  logic [31:0] AddrIn;
  logic [31:0] DataIn;
  logic En;
  logic [TBURST_W-1:0] tburst;
  logic addr_mode;
  logic [TLAT_W-1:0] tlat;
  logic [TPRE_W-1:0] tpre;
  logic [TWAIT_W-1:0] twait;
  logic [TCAS_W-1:0] tcas;
  logic prog_mode;
  modport master (
    output MasterBusy, AddrIn, DataIn, En,
    input tburst, addr_mode, tlat, tpre, twait, tcas, prog_mode
  );
  modport slave (
    input MasterBusy, AddrIn, DataIn, En,
    output tburst, addr_mode, tlat, tpre, twait, tcas, prog_mode
  );
endinterface

// File: rtl/biu_addr_decode.sv
// biu_addr_decode: qualifies a bus write to one register address
module biu_addr_decode #(
  parameter logic [31:0] ADDR = 32'h3FFF_FFFF
) (
  input  logic        en,
  input  logic        master_busy,
  input  logic [31:0] addr,
  output logic        wr
);
  assign wr = en & ~master_busy & (addr == ADDR);
endmodule

// File: rtl/biu_regfile.sv
// biu_regfile: bus-written SDRAM configuration word driving timing/mode fields
module biu_regfile
  import biu_pkg::*;
#(
  parameter logic [31:0] REG_ADDR = BIU_REG_ADDR,
  parameter logic [31:0] RST_CFG = 32'h0000_0000
) (
  input logic Clk,
  input logic Rst,
  biu_regfile_if.slave bus
);
  logic wr;
  logic [31:0] cfg;
  logic prog_q;
  biu_addr_decode #(.ADDR(REG_ADDR)) u_dec (
    .en(bus.En),
    .master_busy(bus.MasterBusy),
    .addr(bus.AddrIn),
    .wr(wr)
  );
  // load the whole word on a qualified write; prog flag marks the cycle after it
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cfg <= RST_CFG;
      prog_q <= 1'b0;
    end else begin
      prog_q <= wr;
      if (wr) cfg <= bus.DataIn;
    end
  end
  assign bus.tburst = cfg[TBURST_LSB +: TBURST_W];
  assign bus.addr_mode = cfg[ADDR_MODE_LSB];
  assign bus.tlat = cfg[TLAT_LSB +: TLAT_W];
  assign bus.tpre = cfg[TPRE_LSB +: TPRE_W];
  assign bus.twait = cfg[TWAIT_LSB +: TWAIT_W];
  assign bus.tcas = cfg[TCAS_LSB +: TCAS_W];
  assign bus.prog_mode = prog_q;
endmodule

// File: tb/tb_biu_regfile.sv
// tb_biu_regfile: directed checks of write qualification, latency and async reset
module tb_biu_regfile;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int total = 0;
  int passed = 0;
  biu_regfile_if bus ();
  biu_regfile dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask
  task automatic check_cfg(input string tag, input logic [31:0] exp, input logic prog);
    check({tag, "_cfg"}, {bus.tcas, bus.twait, bus.tpre, bus.tlat, bus.addr_mode, bus.tburst}, exp);
    check({tag, "_prog"}, {31'd0, bus.prog_mode}, {31'd0, prog});
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic drive(input logic en, input logic busy, input logic [31:0] addr, input logic [31:0] data);
    bus.En = en;
    bus.MasterBusy = busy;
    bus.AddrIn = addr;
    bus.DataIn = data;
  endtask
  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #2 Rst = 1'b1;
    #1 check_cfg("reset_async", 32'h0, 1'b0);
    step();
    check_cfg("reset_hold", 32'h0, 1'b0);
    Rst = 1'b0;
    drive(1'b1, 1'b0, 32'h3FFF_FFFF, 32'h1234_5678);
    step();
    check_cfg("write_nonzero", 32'h1234_5678, 1'b1);
    drive(1'b1, 1'b0, 32'h3FFF_FFFF, 32'h0);
    step();
    check_cfg("write_zero", 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0123_4567, 32'h0607_08AF);
    step();
    check_cfg("addr_miss", 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h3FFF_FFFE, 32'h0607_08AF);
    step();
    check_cfg("addr_miss_lsb", 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h3FFF_FFFF, 32'hABCD_EF12);
    step();
    check_cfg("busy_block", 32'h0, 1'b0);
    bus.MasterBusy = 1'b0;
    step();
    check("busy_drop_tcas", {24'd0, bus.tcas}, 32'hAB);
    check("busy_drop_twait", {24'd0, bus.twait}, 32'hCD);
    check("busy_drop_tpre", {24'd0, bus.tpre}, 32'hEF);
    check("busy_drop_tlat", {28'd0, bus.tlat}, 32'h1);
    check("busy_drop_addr_mode", {31'd0, bus.addr_mode}, 32'h0);
    check("busy_drop_tburst", {29'd0, bus.tburst}, 32'h2);
    check("busy_drop_prog", {31'd0, bus.prog_mode}, 32'h1);
    step();
    check_cfg("back_to_back", 32'hABCD_EF12, 1'b1);
    drive(1'b0, 1'b0, 32'h3FFF_FFFF, 32'h0000_000F);
    step();
    check_cfg("enable_off", 32'hABCD_EF12, 1'b0);
    drive(1'b0, 1'b1, 32'h3FFF_FFFF, 32'h0000_000F);
    step();
    check_cfg("enable_off_busy", 32'hABCD_EF12, 1'b0);
    drive(1'b1, 1'b0, 32'h3FFF_FFFF, 32'h55AA_33CC);
    #2 Rst = 1'b1;
    #1 check_cfg("reset_mid", 32'h0, 1'b0);
    step();
    check_cfg("reset_mid_hold", 32'h0, 1'b0);
    Rst = 1'b0;
    step();
    check_cfg("after_reset_write", 32'h55AA_33CC, 1'b1);
    bus.En = 1'b0;
    step();
    check_cfg("after_reset_idle", 32'h55AA_33CC, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
